// File: rtl/fejkon_led_sequencer.sv
// Status LED sequencer for the four FC ports.
// After reset it runs a lamp test: all LEDs lit, then a walking light
// across the bracket/board LEDs. It then maps port alignment, activity,
// traffic and transceiver reconfig status onto active-low LED patterns.
module fejkon_led_sequencer #(
  parameter int unsigned ReferenceClock = 50000000,
  parameter int unsigned TickHz         = 1000,
  parameter int unsigned LampTestTicks  = 250,
  parameter int unsigned BlinkTicks     = 250,
  parameter int unsigned StretchTicks   = 50,
  parameter int unsigned HeartbeatTicks = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fcport0_aligned,
  input  logic       fcport1_aligned,
  input  logic       fcport2_aligned,
  input  logic       fcport3_aligned,
  input  logic       fcport0_active,
  input  logic       fcport1_active,
  input  logic       fcport2_active,
  input  logic       fcport3_active,
  input  logic       fcport0_traffic,
  input  logic       fcport1_traffic,
  input  logic       fcport2_traffic,
  input  logic       fcport3_traffic,
  input  logic       reconfig_busy,
  output logic [3:0] led_bracket,
  output logic [3:0] led_board,
  output logic [1:0] led_rj45
);

  localparam int unsigned PrescPeriod = ReferenceClock / TickHz;
  localparam int unsigned PrescW      = (PrescPeriod > 1) ? $clog2(PrescPeriod) : 1;
  localparam int unsigned LampW       = $clog2(LampTestTicks + 1);
  localparam int unsigned BlinkW      = $clog2(BlinkTicks + 1);
  localparam int unsigned StretchW    = $clog2(StretchTicks + 1);
  localparam int unsigned HbW         = $clog2(HeartbeatTicks + 1);

  localparam logic [PrescW-1:0]   PrescLast   = PrescW'(PrescPeriod - 1);
  localparam logic [LampW-1:0]    LampLast    = LampW'(LampTestTicks - 1);
  localparam logic [BlinkW-1:0]   BlinkLast   = BlinkW'(BlinkTicks - 1);
  localparam logic [StretchW-1:0] FastLast    = StretchW'(StretchTicks - 1);
  localparam logic [HbW-1:0]      HbLast      = HbW'(HeartbeatTicks - 1);
  localparam logic [StretchW-1:0] StretchLoad = StretchW'(StretchTicks);

  typedef enum logic [1:0] {LAMP_ALL, WALK, RUN} state_e;

  logic [12:0]         asyncIn;
  logic [12:0]         sync1_q, sync2_q;
  logic [3:0]          trafficDly_q;
  logic [3:0]          alignedSync, activeSync, trafficSync, trafficEvent;
  logic                busySync;
  logic [PrescW-1:0]   presc_q;
  logic                tick;
  logic [BlinkW-1:0]   slowCnt_q;
  logic [StretchW-1:0] fastCnt_q;
  logic [HbW-1:0]      hbCnt_q;
  logic                slowPhase_q, fastPhase_q, hbPhase_q;
  logic [StretchW-1:0] stretch_q [4];
  logic [StretchW-1:0] busyStretch_q;
  state_e              state_q, state_d;
  logic [LampW-1:0]    stepCnt_q, stepCnt_d;
  logic [1:0]          walkIdx_q, walkIdx_d;
  logic [3:0]          bracket_d, board_d, ledBracket_q, ledBoard_q;
  logic [1:0]          rj45_d, ledRj45_q;

  assign asyncIn = {reconfig_busy,
                    fcport3_traffic, fcport2_traffic, fcport1_traffic, fcport0_traffic,
                    fcport3_active, fcport2_active, fcport1_active, fcport0_active,
                    fcport3_aligned, fcport2_aligned, fcport1_aligned, fcport0_aligned};

  assign alignedSync  = sync2_q[3:0];
  assign activeSync   = sync2_q[7:4];
  assign trafficSync  = sync2_q[11:8];
  assign busySync     = sync2_q[12];
  assign trafficEvent = trafficSync ^ trafficDly_q;
  assign tick         = (presc_q == PrescLast);

  assign led_bracket = ledBracket_q;
  assign led_board   = ledBoard_q;
  assign led_rj45    = ledRj45_q;

  // Two-stage synchronisers for every async input, plus a third stage on traffic for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      trafficDly_q <= '0;
    end else begin
      sync1_q      <= asyncIn;
      sync2_q      <= sync1_q;
      trafficDly_q <= trafficSync;
    end
  end

  // Prescaler producing a single-cycle tick at terminal count
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PrescW'(1);
    end
  end

  // Free-running slow blink, fast flicker and heartbeat phases
  always_ff @(posedge clk) begin
    if (reset) begin
      slowCnt_q   <= '0;
      fastCnt_q   <= '0;
      hbCnt_q     <= '0;
      slowPhase_q <= 1'b0;
      fastPhase_q <= 1'b0;
      hbPhase_q   <= 1'b0;
    end else if (tick) begin
      if (slowCnt_q == BlinkLast) begin
        slowCnt_q   <= '0;
        slowPhase_q <= ~slowPhase_q;
      end else begin
        slowCnt_q <= slowCnt_q + BlinkW'(1);
      end
      if (fastCnt_q == FastLast) begin
        fastCnt_q   <= '0;
        fastPhase_q <= ~fastPhase_q;
      end else begin
        fastCnt_q <= fastCnt_q + StretchW'(1);
      end
      if (hbCnt_q == HbLast) begin
        hbCnt_q   <= '0;
        hbPhase_q <= ~hbPhase_q;
      end else begin
        hbCnt_q <= hbCnt_q + HbW'(1);
      end
    end
  end

  // Traffic and reconfig stretchers: a new event reloads and beats a same-cycle tick
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < 4; p++) stretch_q[p] <= '0;
      busyStretch_q <= '0;
    end else begin
      for (int p = 0; p < 4; p++) begin
        if (trafficEvent[p]) begin
          stretch_q[p] <= StretchLoad;
        end else if (tick && stretch_q[p] != '0) begin
          stretch_q[p] <= stretch_q[p] - StretchW'(1);
        end
      end
      if (busySync) begin
        busyStretch_q <= StretchLoad;
      end else if (tick && busyStretch_q != '0) begin
        busyStretch_q <= busyStretch_q - StretchW'(1);
      end
    end
  end

  // Global FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= LAMP_ALL;
      stepCnt_q <= '0;
      walkIdx_q <= '0;
    end else begin
      state_q   <= state_d;
      stepCnt_q <= stepCnt_d;
      walkIdx_q <= walkIdx_d;
    end
  end

  // Lamp-test sequencing, advancing one step every LampTestTicks ticks until RUN
  always_comb begin
    state_d   = state_q;
    stepCnt_d = stepCnt_q;
    walkIdx_d = walkIdx_q;
    if (tick && state_q != RUN) begin
      if (stepCnt_q == LampLast) begin
        stepCnt_d = '0;
        case (state_q)
          LAMP_ALL: begin
            state_d   = WALK;
            walkIdx_d = '0;
          end
          WALK: begin
            if (walkIdx_q == 2'd3) state_d = RUN;
            else walkIdx_d = walkIdx_q + 2'd1;
          end
          default: ;
        endcase
      end else begin
        stepCnt_d = stepCnt_q + LampW'(1);
      end
    end
  end

  // LED pattern selection per state; in RUN an unaligned port is always dark
  always_comb begin
    bracket_d = 4'hF;
    board_d   = 4'hF;
    rj45_d    = 2'b11;
    case (state_q)
      LAMP_ALL: begin
        bracket_d = 4'h0;
        board_d   = 4'h0;
        rj45_d    = 2'b00;
      end
      WALK: begin
        bracket_d = ~(4'b0001 << walkIdx_q);
        board_d   = ~(4'b0001 << walkIdx_q);
      end
      RUN: begin
        for (int p = 0; p < 4; p++) begin
          if (!alignedSync[p]) begin
            bracket_d[p] = 1'b1;
            board_d[p]   = 1'b1;
          end else if (!activeSync[p]) begin
            bracket_d[p] = ~slowPhase_q;
            board_d[p]   = 1'b0;
          end else if (stretch_q[p] == '0) begin
            bracket_d[p] = 1'b0;
            board_d[p]   = 1'b0;
          end else begin
            bracket_d[p] = fastPhase_q;
            board_d[p]   = 1'b0;
          end
        end
        rj45_d[0] = ~(busySync || busyStretch_q != '0);
        rj45_d[1] = hbPhase_q;
      end
      default: ;
    endcase
  end

  // Registered LED outputs, dark while in reset
  always_ff @(posedge clk) begin
    if (reset) begin
      ledBracket_q <= 4'hF;
      ledBoard_q   <= 4'hF;
      ledRj45_q    <= 2'b11;
    end else begin
      ledBracket_q <= bracket_d;
      ledBoard_q   <= board_d;
      ledRj45_q    <= rj45_d;
    end
  end

endmodule

// File: tb/tb_fejkon_led_sequencer.sv
// Directed bench for fejkon_led_sequencer with a 10-cycle tick.
// cyc counts clock edges since reset release; expected LED values are
// hand-derived from that count (ticks land on edges 10,20,...).
module tb_fejkon_led_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] aligned = '0;
  logic [3:0] active = '0;
  logic [3:0] traffic = '0;
  logic       busy = 1'b0;
  logic [3:0] led_bracket, led_board;
  logic [1:0] led_rj45;
  logic [9:0] allOut;
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;

  assign allOut = {led_bracket, led_board, led_rj45};

  fejkon_led_sequencer #(
    .ReferenceClock(100), .TickHz(10), .LampTestTicks(2),
    .BlinkTicks(3), .StretchTicks(2), .HeartbeatTicks(4)
  ) dut (
    .clk(clk), .reset(reset),
    .fcport0_aligned(aligned[0]), .fcport1_aligned(aligned[1]),
    .fcport2_aligned(aligned[2]), .fcport3_aligned(aligned[3]),
    .fcport0_active(active[0]), .fcport1_active(active[1]),
    .fcport2_active(active[2]), .fcport3_active(active[3]),
    .fcport0_traffic(traffic[0]), .fcport1_traffic(traffic[1]),
    .fcport2_traffic(traffic[2]), .fcport3_traffic(traffic[3]),
    .reconfig_busy(busy),
    .led_bracket(led_bracket), .led_board(led_board), .led_rj45(led_rj45)
  );

  always #5 clk = ~clk;

  // Edge counter since reset release
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else cyc <= cyc + 1;
  end

  // Advance to 1 time unit after edge c; an overrun is a failed check
  task automatic goTo(input int c);
    int n = 0;
    while (cyc < c && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (cyc != c) begin
      checks++;
      errors++;
      $display("[TB] FAIL goto_%0d: got cycle %0d expected %0d", c, cyc, c);
    end
  endtask

  // Reset darkness, lamp test and walking light, then RUN entry
  task automatic test_reset;
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (allOut !== 10'h3FF) begin errors++; $display("[TB] FAIL reset_dark: got %b expected %b", allOut, 10'h3FF); end
    reset = 1'b0;
    goTo(1);
    checks++; if (allOut !== 10'h000) begin errors++; $display("[TB] FAIL lamp_all_start: got %b expected %b", allOut, 10'h000); end
    goTo(20);
    checks++; if (allOut !== 10'h000) begin errors++; $display("[TB] FAIL lamp_all_end: got %b expected %b", allOut, 10'h000); end
    goTo(21);
    checks++; if (allOut !== 10'b1110_1110_11) begin errors++; $display("[TB] FAIL walk0: got %b expected %b", allOut, 10'b1110_1110_11); end
    goTo(40);
    checks++; if (allOut !== 10'b1110_1110_11) begin errors++; $display("[TB] FAIL walk0_end: got %b expected %b", allOut, 10'b1110_1110_11); end
    goTo(41);
    checks++; if (allOut !== 10'b1101_1101_11) begin errors++; $display("[TB] FAIL walk1: got %b expected %b", allOut, 10'b1101_1101_11); end
    goTo(61);
    checks++; if (allOut !== 10'b1011_1011_11) begin errors++; $display("[TB] FAIL walk2: got %b expected %b", allOut, 10'b1011_1011_11); end
    goTo(81);
    checks++; if (allOut !== 10'b0111_0111_11) begin errors++; $display("[TB] FAIL walk3: got %b expected %b", allOut, 10'b0111_0111_11); end
    goTo(100);
    checks++; if (allOut !== 10'b0111_0111_11) begin errors++; $display("[TB] FAIL walk3_end: got %b expected %b", allOut, 10'b0111_0111_11); end
    goTo(101);
    checks++; if (allOut !== 10'b1111_1111_01) begin errors++; $display("[TB] FAIL run_entry: got %b expected %b", allOut, 10'b1111_1111_01); end
  endtask

  // Port0 aligned but inactive: board lit after 3 cycles, bracket slow blink every 30 cycles
  task automatic test_slow_blink;
    goTo(110);
    aligned[0] = 1'b1;
    goTo(112);
    checks++; if (led_board[0] !== 1'b1) begin errors++; $display("[TB] FAIL p0_board_latency: got %b expected %b", led_board[0], 1'b1); end
    goTo(113);
    checks++; if (led_board[0] !== 1'b0) begin errors++; $display("[TB] FAIL p0_board_lit: got %b expected %b", led_board[0], 1'b0); end
    checks++; if (led_bracket[0] !== 1'b0) begin errors++; $display("[TB] FAIL p0_blink_113: got %b expected %b", led_bracket[0], 1'b0); end
    goTo(120);
    checks++; if (led_bracket[0] !== 1'b0) begin errors++; $display("[TB] FAIL p0_blink_120: got %b expected %b", led_bracket[0], 1'b0); end
    goTo(121);
    checks++; if (led_bracket[0] !== 1'b1) begin errors++; $display("[TB] FAIL p0_blink_121: got %b expected %b", led_bracket[0], 1'b1); end
    goTo(150);
    checks++; if (led_bracket[0] !== 1'b1) begin errors++; $display("[TB] FAIL p0_blink_150: got %b expected %b", led_bracket[0], 1'b1); end
    goTo(151);
    checks++; if (led_bracket[0] !== 1'b0) begin errors++; $display("[TB] FAIL p0_blink_151: got %b expected %b", led_bracket[0], 1'b0); end
  endtask

  // Port1 active, single traffic toggle: flicker for two ticks then solid
  task automatic test_traffic;
    goTo(160);
    aligned[1] = 1'b1;
    active[1]  = 1'b1;
    goTo(162);
    checks++; if (led_board[1] !== 1'b1) begin errors++; $display("[TB] FAIL p1_board_latency: got %b expected %b", led_board[1], 1'b1); end
    goTo(163);
    checks++; if ({led_bracket[1], led_board[1]} !== 2'b00) begin errors++; $display("[TB] FAIL p1_solid: got %b expected %b", {led_bracket[1], led_board[1]}, 2'b00); end
    goTo(170);
    traffic[1] = ~traffic[1];
    goTo(180);
    checks++; if (led_bracket[1] !== 1'b0) begin errors++; $display("[TB] FAIL p1_fast_low: got %b expected %b", led_bracket[1], 1'b0); end
    goTo(181);
    checks++; if (led_bracket[1] !== 1'b1) begin errors++; $display("[TB] FAIL p1_flicker_on: got %b expected %b", led_bracket[1], 1'b1); end
    goTo(190);
    checks++; if (led_bracket[1] !== 1'b1) begin errors++; $display("[TB] FAIL p1_flicker_190: got %b expected %b", led_bracket[1], 1'b1); end
    goTo(191);
    checks++; if (led_bracket[1] !== 1'b0) begin errors++; $display("[TB] FAIL p1_stretch_done: got %b expected %b", led_bracket[1], 1'b0); end
  endtask

  // Port1 traffic every 15 cycles, first load landing on a tick edge
  task automatic test_back_to_back;
    goTo(217);
    traffic[1] = ~traffic[1];
    goTo(221);
    checks++; if (led_bracket[1] !== 1'b1) begin errors++; $display("[TB] FAIL b2b_load_on_tick: got %b expected %b", led_bracket[1], 1'b1); end
    goTo(232);
    traffic[1] = ~traffic[1];
    goTo(239);
    checks++; if (led_bracket[1] !== 1'b1) begin errors++; $display("[TB] FAIL b2b_239: got %b expected %b", led_bracket[1], 1'b1); end
    goTo(245);
    checks++; if (led_bracket[1] !== 1'b0) begin errors++; $display("[TB] FAIL b2b_245: got %b expected %b", led_bracket[1], 1'b0); end
    goTo(247);
    traffic[1] = ~traffic[1];
    goTo(261);
    checks++; if (led_bracket[1] !== 1'b1) begin errors++; $display("[TB] FAIL b2b_261: got %b expected %b", led_bracket[1], 1'b1); end
    goTo(262);
    traffic[1] = ~traffic[1];
    goTo(275);
    checks++; if (led_bracket[1] !== 1'b1) begin errors++; $display("[TB] FAIL b2b_275: got %b expected %b", led_bracket[1], 1'b1); end
    goTo(280);
    checks++; if (led_bracket[1] !== 1'b1) begin errors++; $display("[TB] FAIL b2b_280: got %b expected %b", led_bracket[1], 1'b1); end
    goTo(281);
    checks++; if ({led_bracket[1], led_board[1]} !== 2'b00) begin errors++; $display("[TB] FAIL b2b_done: got %b expected %b", {led_bracket[1], led_board[1]}, 2'b00); end
  endtask

  // Port2 loses alignment while its stretch is running
  task automatic test_align_drop;
    goTo(318);
    aligned[2] = 1'b1;
    active[2]  = 1'b1;
    goTo(321);
    checks++; if ({led_bracket[2], led_board[2]} !== 2'b00) begin errors++; $display("[TB] FAIL p2_solid: got %b expected %b", {led_bracket[2], led_board[2]}, 2'b00); end
    goTo(327);
    traffic[2] = ~traffic[2];
    goTo(333);
    aligned[2] = 1'b0;
    goTo(335);
    checks++; if ({led_bracket[2], led_board[2]} !== 2'b00) begin errors++; $display("[TB] FAIL p2_before_drop: got %b expected %b", {led_bracket[2], led_board[2]}, 2'b00); end
    goTo(336);
    checks++; if ({led_bracket[2], led_board[2]} !== 2'b11) begin errors++; $display("[TB] FAIL p2_dark: got %b expected %b", {led_bracket[2], led_board[2]}, 2'b11); end
    goTo(340);
    checks++; if ({led_bracket[2], led_board[2]} !== 2'b11) begin errors++; $display("[TB] FAIL p2_dark_340: got %b expected %b", {led_bracket[2], led_board[2]}, 2'b11); end
  endtask

  // One-cycle reconfig pulse stretched over two ticks; heartbeat every 40 cycles
  task automatic test_reconfig;
    goTo(367);
    busy = 1'b1;
    goTo(368);
    busy = 1'b0;
    goTo(369);
    checks++; if (led_rj45 !== 2'b11) begin errors++; $display("[TB] FAIL rj45_before: got %b expected %b", led_rj45, 2'b11); end
    goTo(370);
    checks++; if (led_rj45 !== 2'b10) begin errors++; $display("[TB] FAIL rj45_busy_lit: got %b expected %b", led_rj45, 2'b10); end
    goTo(385);
    checks++; if (led_rj45[0] !== 1'b0) begin errors++; $display("[TB] FAIL rj45_stretch_385: got %b expected %b", led_rj45[0], 1'b0); end
    goTo(390);
    checks++; if (led_rj45[0] !== 1'b0) begin errors++; $display("[TB] FAIL rj45_stretch_390: got %b expected %b", led_rj45[0], 1'b0); end
    goTo(391);
    checks++; if (led_rj45[0] !== 1'b1) begin errors++; $display("[TB] FAIL rj45_released: got %b expected %b", led_rj45[0], 1'b1); end
    goTo(400);
    checks++; if (led_rj45[1] !== 1'b1) begin errors++; $display("[TB] FAIL hb_400: got %b expected %b", led_rj45[1], 1'b1); end
    goTo(401);
    checks++; if (led_rj45[1] !== 1'b0) begin errors++; $display("[TB] FAIL hb_401: got %b expected %b", led_rj45[1], 1'b0); end
    goTo(441);
    checks++; if (led_rj45[1] !== 1'b1) begin errors++; $display("[TB] FAIL hb_441: got %b expected %b", led_rj45[1], 1'b1); end
  endtask

  // Reset in RUN darkens everything next cycle and replays the lamp test
  task automatic test_reset_mid_run;
    goTo(445);
    checks++; if (allOut !== 10'b1101_1100_11) begin errors++; $display("[TB] FAIL run_before_reset: got %b expected %b", allOut, 10'b1101_1100_11); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (allOut !== 10'h3FF) begin errors++; $display("[TB] FAIL midrun_reset_dark: got %b expected %b", allOut, 10'h3FF); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (allOut !== 10'h3FF) begin errors++; $display("[TB] FAIL midrun_reset_hold: got %b expected %b", allOut, 10'h3FF); end
    reset = 1'b0;
    goTo(1);
    checks++; if (allOut !== 10'h000) begin errors++; $display("[TB] FAIL relamp_all: got %b expected %b", allOut, 10'h000); end
    goTo(21);
    checks++; if (allOut !== 10'b1110_1110_11) begin errors++; $display("[TB] FAIL rewalk0: got %b expected %b", allOut, 10'b1110_1110_11); end
    goTo(41);
    checks++; if (allOut !== 10'b1101_1101_11) begin errors++; $display("[TB] FAIL rewalk1: got %b expected %b", allOut, 10'b1101_1101_11); end
    goTo(101);
    checks++; if (allOut !== 10'b1100_1100_01) begin errors++; $display("[TB] FAIL rerun_entry: got %b expected %b", allOut, 10'b1100_1100_01); end
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_slow_blink();
    test_traffic();
    test_back_to_back();
    test_align_drop();
    test_reconfig();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
